// File: rtl/wb_writeback_unit.sv
// Writeback: captures MEM results, aligns/extends load data, drives the regfile write port; 2-cycle fixed latency.
// No backpressure: accepts one retiring instruction per cycle and never stalls; Flush kills the W1 entry.
module wb_writeback_unit #(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int INSTRET_WIDTH      = 64
) (
  input  logic                          Clk_100MHz,
  input  logic                          Reset,
  input  logic                          Flush,
  input  logic                          Mem_valid,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Mem_rd_address,
  input  logic                          Mem_rd_wr_en,
  input  logic [REG_DATA_WIDTH-1:0]     Mem_result,
  input  logic                          Mem_is_load,
  input  logic [2:0]                    Mem_load_funct3,
  input  logic [REG_DATA_WIDTH-1:0]     Dmem_rd_data,
  output logic [REGFILE_ADDR_WIDTH-1:0] Rd_address,
  output logic [REG_DATA_WIDTH-1:0]     Rd_wr_data,
  output logic                          Rd_wr_en,
  output logic                          Load_fault,
  output logic [REG_DATA_WIDTH-1:0]     Load_fault_addr,
  output logic [INSTRET_WIDTH-1:0]      Instret
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic                          w1_valid;
  logic [REGFILE_ADDR_WIDTH-1:0] w1_rd_address;
  logic                          w1_rd_wr_en;
  logic [REG_DATA_WIDTH-1:0]     w1_result;
  logic                          w1_is_load;
  logic [2:0]                    w1_funct3;

  logic                      w1_live;
  logic                      illegal;
  logic                      misaligned;
  logic                      fault;
  logic                      do_write;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [REG_DATA_WIDTH-1:0] ld_data;
  logic [REG_DATA_WIDTH-1:0] wb_data;

  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      w1_valid      <= 1'b0;
      w1_rd_address <= '0;
      w1_rd_wr_en   <= 1'b0;
      w1_result     <= '0;
      w1_is_load    <= 1'b0;
      w1_funct3     <= '0;
    end else begin
      w1_valid <= Mem_valid;
      if (Mem_valid) begin
        w1_rd_address <= Mem_rd_address;
        w1_rd_wr_en   <= Mem_rd_wr_en;
        w1_result     <= Mem_result;
        w1_is_load    <= Mem_is_load;
        w1_funct3     <= Mem_load_funct3;
      end
    end
  end

  // Lane select uses the byte offset within the 32-bit memory word.
  always_comb begin
    ld_byte    = Dmem_rd_data[{w1_result[1:0], 3'b000} +: 8];
    ld_half    = Dmem_rd_data[{w1_result[1], 4'b0000} +: 16];
    illegal    = 1'b0;
    misaligned = 1'b0;
    ld_data    = Dmem_rd_data;
    case (w1_funct3)
      F3_LB:  ld_data = {{(REG_DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {{(REG_DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_LH: begin
        ld_data    = {{(REG_DATA_WIDTH-16){ld_half[15]}}, ld_half};
        misaligned = w1_result[0];
      end
      F3_LHU: begin
        ld_data    = {{(REG_DATA_WIDTH-16){1'b0}}, ld_half};
        misaligned = w1_result[0];
      end
      F3_LW:   misaligned = (w1_result[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
    w1_live  = w1_valid && !Flush;
    fault    = w1_is_load && (illegal || misaligned);
    wb_data  = w1_is_load ? ld_data : w1_result;
    do_write = w1_live && !fault && w1_rd_wr_en && (w1_rd_address != '0);
  end

  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      Rd_address      <= '0;
      Rd_wr_data      <= '0;
      Rd_wr_en        <= 1'b0;
      Load_fault      <= 1'b0;
      Load_fault_addr <= '0;
      Instret         <= '0;
    end else begin
      Rd_wr_en   <= do_write;
      Load_fault <= w1_live && fault;
      if (do_write) begin
        Rd_address <= w1_rd_address;
        Rd_wr_data <= wb_data;
      end
      if (w1_live && fault) begin
        Load_fault_addr <= w1_result;
      end
      // x0 and wr_en=0 instructions still retire.
      if (w1_live && !fault) begin
        Instret <= Instret + INSTRET_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: directed instruction table, per-cycle model compare, literal pins.
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        Reset, Flush, Mem_valid, Mem_rd_wr_en, Mem_is_load;
  logic [4:0]  Mem_rd_address;
  logic [31:0] Mem_result, Dmem_rd_data;
  logic [2:0]  Mem_load_funct3;

  logic [4:0]  Rd_address, n_addr;
  logic [31:0] Rd_wr_data, Load_fault_addr, n_data, n_faddr;
  logic        Rd_wr_en, Load_fault, n_we, n_flt;
  logic [63:0] Instret;
  logic [2:0]  n_ir;

  always #5 clk = ~clk;

  wb_writeback_unit #(.REG_DATA_WIDTH(32), .REGFILE_ADDR_WIDTH(5), .INSTRET_WIDTH(64)) dut (
    .Clk_100MHz(clk), .Reset(Reset), .Flush(Flush), .Mem_valid(Mem_valid),
    .Mem_rd_address(Mem_rd_address), .Mem_rd_wr_en(Mem_rd_wr_en), .Mem_result(Mem_result),
    .Mem_is_load(Mem_is_load), .Mem_load_funct3(Mem_load_funct3), .Dmem_rd_data(Dmem_rd_data),
    .Rd_address(Rd_address), .Rd_wr_data(Rd_wr_data), .Rd_wr_en(Rd_wr_en),
    .Load_fault(Load_fault), .Load_fault_addr(Load_fault_addr), .Instret(Instret));

  // Narrow counter instance exercises the modulo wrap in a short run.
  wb_writeback_unit #(.REG_DATA_WIDTH(32), .REGFILE_ADDR_WIDTH(5), .INSTRET_WIDTH(3)) dut_n (
    .Clk_100MHz(clk), .Reset(Reset), .Flush(Flush), .Mem_valid(Mem_valid),
    .Mem_rd_address(Mem_rd_address), .Mem_rd_wr_en(Mem_rd_wr_en), .Mem_result(Mem_result),
    .Mem_is_load(Mem_is_load), .Mem_load_funct3(Mem_load_funct3), .Dmem_rd_data(Dmem_rd_data),
    .Rd_address(n_addr), .Rd_wr_data(n_data), .Rd_wr_en(n_we),
    .Load_fault(n_flt), .Load_fault_addr(n_faddr), .Instret(n_ir));

  typedef struct {
    bit          valid;
    logic [4:0]  rd;
    bit          we;
    logic [31:0] res;
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] dmem;
    bit          kill;
    bit          rst;
    int          lk;
    logic [31:0] lit;
  } stim_t;

  stim_t       st[$];
  logic [63:0] ir_pin[int];
  int          cur = -1;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] DM = 32'h80F17F01;

  task automatic op(input logic [4:0] rd, input bit we, input logic [31:0] res, input bit ld,
                    input logic [2:0] f3, input logic [31:0] dmem, input bit kill,
                    input int lk, input logic [31:0] lit);
    stim_t e;
    e.valid = 1; e.rd = rd; e.we = we; e.res = res; e.ld = ld; e.f3 = f3;
    e.dmem = dmem; e.kill = kill; e.rst = 0; e.lk = lk; e.lit = lit;
    st.push_back(e);
  endtask

  task automatic idle(input bit rst);
    stim_t e;
    e.valid = 0; e.rd = '0; e.we = 0; e.res = 32'h0BAD0BAD; e.ld = 0; e.f3 = '0;
    e.dmem = 32'hA5A5A5A5; e.kill = 0; e.rst = rst; e.lk = 0; e.lit = '0;
    st.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cur, act, exp);
    end
  endtask

  // Load result from access size and byte offset, independent of any lane-mux structure.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word, output bit bad);
    int     size;
    longint v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad  = (f3 == 3'd3) || (f3 >= 3'd6) || ((addr % size) != 0);
    v    = longint'(word >> (8 * (addr % 4)));
    if (size < 4) begin
      v = v % (longint'(1) << (8 * size));
      if (!f3[2] && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
    end
    return v[31:0];
  endfunction

  initial begin
    Reset = 1; Flush = 0; Mem_valid = 0; Mem_rd_address = '0; Mem_rd_wr_en = 0;
    Mem_result = '0; Mem_is_load = 0; Mem_load_funct3 = '0; Dmem_rd_data = '0;

    idle(1); idle(0);                                             // 0,1
    op(5'd5, 1, 32'hDEADBEEF, 0, 3'd0, DM, 0, 1, 32'hDEADBEEF);   // 2
    idle(0); idle(0);                                             // 3,4
    ir_pin[4] = 64'd1;
    op(5'd10, 1, 32'h00000102, 1, 3'b000, DM, 0, 1, 32'hFFFFFFF1); // 5 LB
    op(5'd11, 1, 32'h00000103, 1, 3'b100, DM, 0, 1, 32'h00000080); // 6 LBU
    op(5'd12, 1, 32'h00000102, 1, 3'b001, DM, 0, 1, 32'hFFFF80F1); // 7 LH
    op(5'd13, 1, 32'h00000100, 1, 3'b101, DM, 0, 1, 32'h00007F01); // 8 LHU
    op(5'd14, 1, 32'h00000100, 1, 3'b010, DM, 0, 1, 32'h80F17F01); // 9 LW
    op(5'd15, 1, 32'h00001002, 1, 3'b010, DM, 0, 2, 32'h00001002); // 10 LW misaligned
    op(5'd16, 1, 32'h00002000, 1, 3'b011, DM, 0, 2, 32'h00002000); // 11 illegal
    idle(0); idle(0);                                             // 12,13
    ir_pin[14] = 64'd6;
    op(5'd0, 1, 32'h11, 0, 3'd0, DM, 0, 0, '0);                    // 14 x0
    op(5'd1, 1, 32'h22, 0, 3'd0, DM, 0, 1, 32'h22);                // 15
    op(5'd2, 1, 32'h33, 0, 3'd0, DM, 0, 1, 32'h33);                // 16
    op(5'd3, 1, 32'h44, 0, 3'd0, DM, 1, 0, '0);                    // 17 flushed
    op(5'd20, 1, 32'h99, 0, 3'd0, DM, 0, 1, 32'h99);               // 18 captured under flush
    idle(0); idle(0);                                             // 19,20
    ir_pin[21] = 64'd10;
    op(5'd4, 1, 32'h00000103, 1, 3'b101, DM, 0, 2, 32'h00000103);  // 21 LHU misaligned
    op(5'd6, 0, 32'h00000101, 1, 3'b000, DM, 0, 0, '0);            // 22 no rd write
    op(5'd9, 1, 32'h00000101, 1, 3'b000, 32'h12345678, 0, 1, 32'h56); // 23
    idle(0); idle(0);                                             // 24,25
    ir_pin[26] = 64'd12;
    op(5'd7, 1, 32'h77, 0, 3'd0, DM, 0, 0, '0);                    // 26 killed by reset
    idle(1);                                                      // 27
    idle(0); idle(0); idle(0);                                    // 28-30
    ir_pin[30] = 64'd0;
    for (int i = 31; i < 40; i++) op(5'((i % 31) + 1), 1, 32'(i), 0, 3'd0, DM, 0, 0, '0);
    idle(0); idle(0); idle(0); idle(0);                           // 40-43
    ir_pin[42] = 64'd9;

    for (int k = 0; k < st.size(); k++) begin
      @(posedge clk);
      #1;
      Reset           = st[k].rst;
      Mem_valid       = st[k].valid;
      Mem_rd_address  = st[k].rd;
      Mem_rd_wr_en    = st[k].we;
      Mem_result      = st[k].res;
      Mem_is_load     = st[k].ld;
      Mem_load_funct3 = st[k].f3;
      Dmem_rd_data    = (k > 0) ? st[k-1].dmem : 32'h0;
      Flush           = (k > 0) ? st[k-1].kill : 1'b0;
      cur             = k;
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_faddr, val;
    logic [63:0] m_ir;
    bit          e_we, e_flt, bad, live;
    int          k, i;
    m_addr = '0; m_data = '0; m_faddr = '0; m_ir = '0;
    forever begin
      @(negedge clk);
      if (cur >= 0) begin
        k = cur;
        e_we = 0; e_flt = 0;
        if (st[k].rst) begin
          m_addr = '0; m_data = '0; m_faddr = '0; m_ir = '0;
        end else if (k >= 2) begin
          i    = k - 2;
          live = st[i].valid && !st[i].kill && !st[i].rst && !st[i+1].rst;
          if (live) begin
            bad = 0;
            val = st[i].ld ? model_load(st[i].f3, st[i].res, st[i].dmem, bad) : st[i].res;
            if (bad) begin
              e_flt   = 1;
              m_faddr = st[i].res;
            end else begin
              m_ir = m_ir + 64'd1;
              if (st[i].we && st[i].rd != 5'd0) begin
                e_we   = 1;
                m_addr = st[i].rd;
                m_data = val;
              end
            end
          end
        end
        chk("rd_wr_en", 64'(Rd_wr_en), 64'(e_we));
        chk("rd_address", 64'(Rd_address), 64'(m_addr));
        chk("rd_wr_data", 64'(Rd_wr_data), 64'(m_data));
        chk("load_fault", 64'(Load_fault), 64'(e_flt));
        chk("load_fault_addr", 64'(Load_fault_addr), 64'(m_faddr));
        chk("instret", Instret, m_ir);
        chk("narrow_instret", 64'(n_ir), 64'(m_ir[2:0]));
        chk("narrow_port", {n_we, n_addr, n_data, n_flt, n_faddr},
            {e_we, m_addr, m_data, e_flt, m_faddr});
        if (k >= 2 && st[k-2].lk == 1 && !st[k].rst) begin
          chk("lit_wr_en", 64'(Rd_wr_en), 64'd1);
          chk("lit_wr_data", 64'(Rd_wr_data), 64'(st[k-2].lit));
        end
        if (k >= 2 && st[k-2].lk == 2 && !st[k].rst) begin
          chk("lit_fault", 64'({Load_fault, Rd_wr_en}), 64'b10);
          chk("lit_fault_addr", 64'(Load_fault_addr), 64'(st[k-2].lit));
        end
        if (ir_pin.exists(k)) begin
          chk("lit_instret", Instret, ir_pin[k]);
          chk("lit_narrow_instret", 64'(n_ir), 64'(ir_pin[k][2:0]));
        end
      end
    end
  end

endmodule
